// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control-bit positions, field widths,
// and the memory-stage state encoding.
package mips_pipe_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   localparam int MEM_BRANCH  = 2;
   localparam int MEM_READ    = 1;
   localparam int MEM_WRITE   = 0;
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_t;

   // A faulted access must never update the register file.
   function automatic logic [1:0] kill_regwrite(input logic [1:0] wb);
      logic [1:0] r;
      r              = wb;
      r[WB_REGWRITE] = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
interface mem_stage_ctrl_if;
   import mips_pipe_pkg::*;

   logic              dmem_req;
   logic              dmem_we;
   logic [DATA_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_ack;
   logic [DATA_W-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/mem_stage_ctrl.sv
// MIPS memory stage: resolves branches, runs the data-memory handshake with a
// timeout, and registers the MEM/WB word. Stalls upstream while an access is open.
module mem_stage_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] adder2,
   input  logic              zero,
   input  logic [DATA_W-1:0] Aluresult,
   input  logic [DATA_W-1:0] ReadData2,
   input  logic [REG_W-1:0]  Mux,
   input  logic [1:0]        WB,
   input  logic [2:0]        Memoria,
   output logic              stall,
   output logic              pcsrc,
   output logic [DATA_W-1:0] branch_target,
   mem_stage_ctrl_if.master  dmem,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_readdata,
   output logic [DATA_W-1:0] wb_aluresult,
   output logic [REG_W-1:0]  wb_rd,
   output logic [1:0]        wb_ctrl,
   output logic              mem_fault
);

   localparam int               CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   mem_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic              req_q;
   logic              we_q;
   logic [DATA_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [REG_W-1:0]  rd_q;
   logic [1:0]        wb_q;

   logic is_mem;
   logic misaligned;

   assign is_mem     = Memoria[MEM_READ] | Memoria[MEM_WRITE];
   assign misaligned = (Aluresult[1:0] != 2'b00);

   assign stall         = (state == ACCESS);
   assign pcsrc         = in_valid & Memoria[MEM_BRANCH] & zero & (state == IDLE);
   assign branch_target = adder2;

   // we is gated by req so a finished store does not leave the write strobe up.
   assign dmem.dmem_req   = req_q;
   assign dmem.dmem_we    = req_q & we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rd_q         <= '0;
         wb_q         <= '0;
         wb_valid     <= 1'b0;
         wb_readdata  <= '0;
         wb_aluresult <= '0;
         wb_rd        <= '0;
         wb_ctrl      <= '0;
         mem_fault    <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (is_mem && !misaligned) begin
                     // Read+write together is treated as a store.
                     addr_q  <= Aluresult;
                     wdata_q <= ReadData2;
                     rd_q    <= Mux;
                     wb_q    <= WB;
                     we_q    <= Memoria[MEM_WRITE];
                     req_q   <= 1'b1;
                     cnt     <= '0;
                     state   <= ACCESS;
                  end else begin
                     wb_valid     <= 1'b1;
                     wb_readdata  <= '0;
                     wb_aluresult <= Aluresult;
                     wb_rd        <= Mux;
                     if (is_mem) begin
                        wb_ctrl   <= kill_regwrite(WB);
                        mem_fault <= 1'b1;
                     end else begin
                        wb_ctrl <= WB;
                     end
                  end
               end
            end
            ACCESS: begin
               // An ack in the last allowed cycle takes priority over the abort.
               if (dmem.dmem_ack || (cnt == CNT_LAST)) begin
                  state        <= IDLE;
                  req_q        <= 1'b0;
                  wb_valid     <= 1'b1;
                  wb_aluresult <= addr_q;
                  wb_rd        <= rd_q;
                  if (dmem.dmem_ack) begin
                     wb_readdata <= we_q ? '0 : dmem.dmem_rdata;
                     wb_ctrl     <= wb_q;
                  end else begin
                     wb_readdata <= '0;
                     wb_ctrl     <= kill_regwrite(wb_q);
                     mem_fault   <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus randomized ops, each checked
// against a transaction-level model of the expected MEM/WB outcome.
module tb_mem_stage_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] adder2;
   logic        zero;
   logic [31:0] Aluresult;
   logic [31:0] ReadData2;
   logic [4:0]  Mux;
   logic [1:0]  WB;
   logic [2:0]  Memoria;
   logic        stall;
   logic        pcsrc;
   logic [31:0] branch_target;
   logic        wb_valid;
   logic [31:0] wb_readdata;
   logic [31:0] wb_aluresult;
   logic [4:0]  wb_rd;
   logic [1:0]  wb_ctrl;
   logic        mem_fault;

   mem_stage_ctrl_if dmem();

   mem_stage_ctrl #(.TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .adder2        (adder2),
      .zero          (zero),
      .Aluresult     (Aluresult),
      .ReadData2     (ReadData2),
      .Mux           (Mux),
      .WB            (WB),
      .Memoria       (Memoria),
      .stall         (stall),
      .pcsrc         (pcsrc),
      .branch_target (branch_target),
      .dmem          (dmem.master),
      .wb_valid      (wb_valid),
      .wb_readdata   (wb_readdata),
      .wb_aluresult  (wb_aluresult),
      .wb_rd         (wb_rd),
      .wb_ctrl       (wb_ctrl),
      .mem_fault     (mem_fault)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit model_fault = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic scramble_inputs();
      adder2    = $urandom;
      Aluresult = $urandom;
      ReadData2 = $urandom;
      Mux       = 5'($urandom);
      WB        = 2'($urandom);
      Memoria   = 3'($urandom);
      zero      = 1'($urandom);
   endtask

   // One op presented in IDLE; memory acks in ACCESS cycle ack_k (ack_k > TO means never).
   task automatic do_op(input bit rd, input bit wr, input bit br, input bit z,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] tgt, input logic [4:0] rdst,
                        input logic [1:0] wbc, input int ack_k, input logic [31:0] rdat);
      bit          mem, mis, acked, ok;
      int          n;
      logic [31:0] exp_rdata;
      in_valid  = 1'b1;
      Aluresult = addr;
      ReadData2 = wdata;
      adder2    = tgt;
      Mux       = rdst;
      WB        = wbc;
      Memoria   = {br, rd, wr};
      zero      = z;
      #1;
      chk("pcsrc", 32'(pcsrc), 32'(br & z));
      chk("branch_target", branch_target, tgt);
      chk("stall_at_accept", 32'(stall), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble_inputs();
      mem   = rd | wr;
      mis   = (addr[1:0] != 2'b00);
      acked = 1'b0;
      if (mem && !mis) begin
         acked = (ack_k <= TO);
         n     = acked ? ack_k : TO;
         for (int c = 1; c <= n; c++) begin
            chk("dmem_req", 32'(dmem.dmem_req), 32'd1);
            chk("stall_access", 32'(stall), 32'd1);
            chk("dmem_we", 32'(dmem.dmem_we), 32'(wr));
            chk("dmem_addr", dmem.dmem_addr, addr);
            if (wr) chk("dmem_wdata", dmem.dmem_wdata, wdata);
            chk("wb_valid_busy", 32'(wb_valid), 32'd0);
            if (c == ack_k) begin
               dmem.dmem_ack   = 1'b1;
               dmem.dmem_rdata = rdat;
            end
            @(posedge clk); #1;
            dmem.dmem_ack   = 1'b0;
            dmem.dmem_rdata = $urandom;
         end
      end
      ok = !mem || (!mis && acked);
      if (!ok) model_fault = 1'b1;
      exp_rdata = (rd && !wr && ok && mem) ? rdat : 32'd0;
      chk("wb_valid", 32'(wb_valid), 32'd1);
      chk("wb_readdata", wb_readdata, exp_rdata);
      chk("wb_aluresult", wb_aluresult, addr);
      chk("wb_rd", 32'(wb_rd), 32'(rdst));
      chk("wb_ctrl", 32'(wb_ctrl), 32'({wbc[1] & ok, wbc[0]}));
      chk("mem_fault", 32'(mem_fault), 32'(model_fault));
      chk("dmem_req_done", 32'(dmem.dmem_req), 32'd0);
      chk("stall_done", 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk("wb_valid_idle", 32'(wb_valid), 32'd0);
      chk("wb_hold", wb_aluresult, addr);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, 32'(dmem.dmem_req), 32'd0);
      chk({tag, "_we"}, 32'(dmem.dmem_we), 32'd0);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_pcsrc"}, 32'(pcsrc), 32'd0);
      chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
      chk({tag, "_fault"}, 32'(mem_fault), 32'd0);
      chk({tag, "_rdata"}, wb_readdata, 32'd0);
      chk({tag, "_alu"}, wb_aluresult, 32'd0);
      chk({tag, "_rd"}, 32'(wb_rd), 32'd0);
      chk({tag, "_ctrl"}, 32'(wb_ctrl), 32'd0);
      chk({tag, "_addr"}, dmem.dmem_addr, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          rd, wr, br, z;
      logic [31:0] a;
      rst             = 1'b1;
      in_valid        = 1'b0;
      dmem.dmem_ack   = 1'b0;
      dmem.dmem_rdata = 32'h0;
      scramble_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // R-type
      do_op(0, 0, 0, 0, 32'h24, 32'h0, 32'h0, 5'd9, 2'b10, 1, 32'h0);
      // load, ack in 3rd ACCESS cycle
      do_op(1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 5'd3, 2'b11, 3, 32'hDEADBEEF);

      // store with immediate ack, next load held on the bus during the stall
      in_valid  = 1'b1;
      Aluresult = 32'h40;
      ReadData2 = 32'h12345678;
      Memoria   = 3'b001;
      WB        = 2'b00;
      Mux       = 5'd0;
      zero      = 1'b0;
      @(posedge clk); #1;
      Aluresult = 32'h44;
      ReadData2 = 32'h0;
      Memoria   = 3'b010;
      WB        = 2'b11;
      Mux       = 5'd7;
      chk("st_req", 32'(dmem.dmem_req), 32'd1);
      chk("st_we", 32'(dmem.dmem_we), 32'd1);
      chk("st_addr", dmem.dmem_addr, 32'h40);
      chk("st_wdata", dmem.dmem_wdata, 32'h12345678);
      chk("st_stall", 32'(stall), 32'd1);
      dmem.dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem.dmem_ack = 1'b0;
      chk("st_wb_valid", 32'(wb_valid), 32'd1);
      chk("st_wb_readdata", wb_readdata, 32'd0);
      chk("st_wb_alu", wb_aluresult, 32'h40);
      chk("st_idle_req", 32'(dmem.dmem_req), 32'd0);
      chk("st_idle_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_req", 32'(dmem.dmem_req), 32'd1);
      chk("b2b_we", 32'(dmem.dmem_we), 32'd0);
      chk("b2b_addr", dmem.dmem_addr, 32'h44);
      chk("b2b_wb_valid", 32'(wb_valid), 32'd0);
      dmem.dmem_ack   = 1'b1;
      dmem.dmem_rdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      dmem.dmem_ack = 1'b0;
      chk("b2b_wb_valid_ack", 32'(wb_valid), 32'd1);
      chk("b2b_readdata", wb_readdata, 32'hCAFEF00D);
      chk("b2b_rd", 32'(wb_rd), 32'd7);
      chk("b2b_ctrl", 32'(wb_ctrl), 32'd3);
      @(posedge clk); #1;
      chk("b2b_single_issue", 32'(dmem.dmem_req), 32'd0);
      chk("b2b_wb_quiet", 32'(wb_valid), 32'd0);

      // branches
      do_op(0, 0, 1, 1, 32'h0, 32'h0, 32'h80, 5'd0, 2'b00, 1, 32'h0);
      do_op(0, 0, 1, 0, 32'h0, 32'h0, 32'h80, 5'd0, 2'b00, 1, 32'h0);
      // timeout, then misaligned load
      do_op(1, 0, 0, 0, 32'h200, 32'h0, 32'h0, 5'd4, 2'b11, TO + 1, 32'h0);
      do_op(1, 0, 0, 0, 32'h102, 32'h0, 32'h0, 5'd5, 2'b11, 1, 32'h0);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       begin rd = 0; wr = 0; end
            1:       begin rd = 1; wr = 0; end
            2:       begin rd = 0; wr = 1; end
            default: begin rd = 1; wr = 1; end
         endcase
         br = 1'($urandom);
         z  = 1'($urandom);
         a  = $urandom;
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         do_op(rd, wr, br, z, a, $urandom, $urandom, 5'($urandom), 2'($urandom),
               $urandom_range(1, TO + 1), $urandom);
      end

      // reset in the middle of an access
      in_valid  = 1'b1;
      Aluresult = 32'h300;
      Memoria   = 3'b010;
      WB        = 2'b11;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("rst_pre_req", 32'(dmem.dmem_req), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst         = 1'b0;
      model_fault = 1'b0;
      chk_all_zero("mid_rst");
      @(posedge clk); #1;
      chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("mid_rst_req", 32'(dmem.dmem_req), 32'd0);

      do_op(1, 0, 0, 0, 32'h500, 32'h0, 32'h0, 5'd12, 2'b11, 2, 32'h0BADF00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller that consumes the EX/MEM pipeline word, resolves branches, runs the data-memory request/acknowledge handshake, and produces the registered MEM/WB word for write-back. It sits between the EX/MEM buffer and the write-back mux. While an access is outstanding it asserts `stall`, which freezes EX/MEM and all earlier stages.

## Interface
- `TIMEOUT`, default 16: cycles allowed in ACCESS without `dmem_ack` before abort; legal range 2..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: EX/MEM word is a real instruction, not a bubble.
- `adder2` in 32: branch target.
- `zero` in 1: ALU zero flag.
- `Aluresult` in 32: ALU result; used as the memory byte address.
- `ReadData2` in 32: store data.
- `Mux` in 5: destination register.
- `WB` in 2: [1] RegWrite, [0] MemtoReg.
- `Memoria` in 3: [2] Branch, [1] MemRead, [0] MemWrite.
- `stall` out 1: hold upstream pipeline registers.
- `pcsrc` out 1: take branch.
- `branch_target` out 32: equals `adder2`.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32, `dmem_wdata` out 32: memory request.
- `dmem_ack` in 1, `dmem_rdata` in 32: memory response. `dmem_rdata` is valid only in the ack cycle.
- `wb_valid` out 1: one-cycle pulse; the MEM/WB word below is new.
- `wb_readdata` out 32, `wb_aluresult` out 32, `wb_rd` out 5, `wb_ctrl` out 2: MEM/WB word.
- `mem_fault` out 1: sticky error flag; cleared only by `rst`.

## Operation
- States: IDLE and ACCESS.
- **Accept:** the incoming word is accepted only in IDLE with `in_valid`=1.
- **Non-memory op** (MemRead=MemWrite=0):
  - MEM/WB registers load at the next edge.
  - `wb_readdata` is cleared to 0.
  - State stays IDLE.
- **Memory op, aligned** (`Aluresult[1:0]`=0):
  - Latch `Aluresult`, `ReadData2`, `Mux`, `WB`, and the op type.
  - Go to ACCESS.
- **Memory op, misaligned:**
  - No request is issued.
  - Set `mem_fault`.
  - MEM/WB loads with `wb_ctrl[1]` (RegWrite) forced to 0; `wb_valid` still pulses.
  - State stays IDLE.
- **MemRead and MemWrite both set:** treated as a write; no read data is captured.
- **ACCESS state:**
  - `dmem_req`=1. `dmem_we`, `dmem_addr` and `dmem_wdata` are taken from the latched values and are stable for the whole state.
  - Cycle counter starts at 0 and increments each cycle.
  - On `dmem_ack`: MEM/WB loads at that edge. `wb_readdata` = `dmem_rdata` for a read, 0 for a write. Return to IDLE.
  - Timeout (counter = TIMEOUT-1 with no ack): abort, set `mem_fault`, load MEM/WB with RegWrite cleared, return to IDLE.
  - An ack arriving in the timeout cycle wins over the timeout.
- **Stall:** `stall` = (state == ACCESS). It is a combinational decode of the state register and is high in the ack cycle.
  - An accepted memory op therefore lets EX/MEM advance once.
  - The following word is held and is accepted in the cycle after return to IDLE.
- **Branch:** `pcsrc` = `in_valid` & Branch & `zero` & (state == IDLE), combinational. `branch_target` = `adder2`. Branch needs no memory access.
- **Reset:**
  - State IDLE, counter 0.
  - `dmem_req`, `dmem_we`, `stall`, `pcsrc`, `wb_valid` and `mem_fault` are 0.
  - All MEM/WB and latched data registers are 0.
  - Reset during ACCESS drops `dmem_req` at the next edge and produces no `wb_valid`.

## Timing
- Non-memory op accepted in cycle T: `wb_valid` and the MEM/WB word appear in T+1.
- Memory op accepted in cycle T:
  - `dmem_req` is high from T+1.
  - If `dmem_ack` arrives in T+k (k ≥ 1), `wb_valid` is in T+k+1, and `stall` is high T+1..T+k.
  - Minimum memory-op latency is 2 cycles.
- Timeout: the ACCESS state lasts exactly TIMEOUT cycles. `mem_fault` and `wb_valid` rise in the cycle after the last ACCESS cycle.
- `wb_valid` is low in every cycle without a new MEM/WB word. The MEM/WB registers hold their value otherwise.
- `pcsrc` is combinational in the accept cycle; there is no registered delay.

## Structure
- Shared package `mips_pipe_pkg` contains:
  - control-bit index constants: `MEM_BRANCH`=2, `MEM_READ`=1, `MEM_WRITE`=0, `WB_REGWRITE`=1, `WB_MEMTOREG`=0;
  - the state enum {IDLE, ACCESS};
  - the field widths 32 and 5.
- Single module; no sub-module is needed. The timeout counter is `$clog2(TIMEOUT)` bits wide.

## Test plan
- **Non-memory op:** R-type with `Aluresult`=0x0000_0024, `Mux`=5'd9, `WB`=2'b10 → T+1: `wb_valid`=1, `wb_aluresult`=0x24, `wb_rd`=9, `wb_ctrl`=10, `stall` never high.
- **Load with delayed ack:** load, `Aluresult`=0x100, memory acks in the 3rd ACCESS cycle with 0xDEAD_BEEF → `stall` high for 3 cycles, `dmem_we`=0, `dmem_addr`=0x100, then `wb_readdata`=0xDEAD_BEEF with `wb_valid`.
- **Store then back-to-back load:** store 0x1234_5678 to 0x40 with immediate ack, followed by the load → `dmem_we`=1, `dmem_wdata`=0x1234_5678. The following load is accepted exactly one cycle after return to IDLE and is not issued twice.
- **Branch:** Branch=1, `zero`=1, `adder2`=0x0000_0080 → `pcsrc`=1 and `branch_target`=0x80 in the same cycle. Repeat with `zero`=0 → `pcsrc`=0.
- **Timeout with TIMEOUT=4, no ack:** → `dmem_req` high exactly 4 cycles, then `mem_fault`=1, `wb_valid`=1 with `wb_ctrl[1]`=0. `mem_fault` stays 1 through later ops.
- **Misaligned address and reset:** load at 0x102 → no `dmem_req`, `mem_fault`=1, `wb_ctrl[1]`=0. Then `rst` asserted mid-ACCESS → `dmem_req`=0 next cycle, no `wb_valid`, all outputs 0.
